// File: rtl/mips_pkg.sv
// mips_pkg: shared types and instruction field positions for the MIPS core
package mips_pkg;
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD, S_DRAIN} fetch_state_t;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam logic [31:0] NOP_INSTR = 32'h0;
endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry buffer parking an acked instruction while IF/ID is stalled
module fetch_hold_buf
  import mips_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        load,
  input  logic        clr,
  input  logic [31:0] instr,
  input  logic [31:0] pc4,
  output logic [31:0] buf_instr,
  output logic [31:0] buf_pc4,
  output logic        full
);
  always_ff @(posedge CLK)
    if (RST) begin
      buf_instr <= NOP_INSTR;
      buf_pc4   <= '0;
      full      <= 1'b0;
    end else if (load) begin
      buf_instr <= instr;
      buf_pc4   <= pc4;
      full      <= 1'b1;
    end else if (clr)
      full <= 1'b0;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC generation, req/ack imem fetch and IF/ID register with stall and redirect
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Stall,
  input  logic        Branch,
  input  logic [31:0] Branch_target,
  input  logic        JtoPC,
  input  logic [31:0] Jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_Valid,
  output logic [4:0]  Read1,
  output logic [4:0]  Read2
);
  fetch_state_t state;
  logic [31:0] pc, pc_step, target, hb_instr, hb_pc4;
  logic redir, hb_full, hb_load, hb_clr;
  assign redir   = Branch | JtoPC;
  assign target  = JtoPC ? Jump_target : Branch_target;
  assign pc_step = pc + PC_STEP;
  assign Read1   = IF_ID_Instr[RS_MSB:RS_LSB];
  assign Read2   = IF_ID_Instr[RT_MSB:RT_LSB];
  assign hb_load = state == S_FETCH && imem_ack && Stall && !redir;
  assign hb_clr  = state == S_HOLD && (redir || !Stall);
  fetch_hold_buf u_hold (
    .CLK(CLK), .RST(RST), .load(hb_load), .clr(hb_clr),
    .instr(imem_rdata), .pc4(pc_step),
    .buf_instr(hb_instr), .buf_pc4(hb_pc4), .full(hb_full)
  );
  always_ff @(posedge CLK)
    if (RST) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      imem_addr   <= RESET_PC;
      imem_req    <= 1'b0;
      IF_ID_Instr <= NOP_INSTR;
      IF_ID_PC4   <= '0;
      IF_ID_Valid <= 1'b0;
    end else
      case (state)
        S_BOOT: begin
          state     <= S_FETCH;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end
        S_FETCH:
          if (redir) begin
            pc          <= target;
            IF_ID_Valid <= 1'b0;
            if (imem_ack) imem_addr <= target;
            else state <= S_DRAIN;
          end else if (imem_ack && !Stall) begin
            IF_ID_Instr <= imem_rdata;
            IF_ID_PC4   <= pc_step;
            IF_ID_Valid <= 1'b1;
            pc          <= pc_step;
            imem_addr   <= pc_step;
          end else if (imem_ack) begin
            state    <= S_HOLD;
            imem_req <= 1'b0;
          end else if (!Stall)
            IF_ID_Valid <= 1'b0;
        S_HOLD:
          if (redir) begin
            state       <= S_FETCH;
            pc          <= target;
            imem_addr   <= target;
            imem_req    <= 1'b1;
            IF_ID_Valid <= 1'b0;
          end else if (!Stall) begin
            state       <= S_FETCH;
            IF_ID_Instr <= hb_instr;
            IF_ID_PC4   <= hb_pc4;
            IF_ID_Valid <= hb_full;
            pc          <= pc_step;
            imem_addr   <= pc_step;
            imem_req    <= 1'b1;
          end
        default: begin
          // stale request still in flight: its data is dropped, and an ack frees the port
          IF_ID_Valid <= 1'b0;
          if (redir) pc <= target;
          if (imem_ack) begin
            state     <= S_FETCH;
            imem_addr <= redir ? target : pc;
          end
        end
      endcase
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors for fetch_stage, plus a second instance checking PC wrap
module tb_fetch_stage;
  logic CLK = 0, RST = 1, Stall = 0, Branch = 0, JtoPC = 0;
  logic [31:0] Branch_target = 0, Jump_target = 0;
  logic ack_mode = 1, ack_force = 0, ovr_en = 0;
  logic imem_req, imem_ack, IF_ID_Valid;
  logic [31:0] imem_addr, imem_rdata, IF_ID_Instr, IF_ID_PC4;
  logic [4:0] Read1, Read2;
  logic w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc4;
  logic [4:0] w_rd1, w_rd2;
  int n_vec = 0, n_bad = 0;
  always #5 CLK = ~CLK;
  assign imem_ack   = ack_mode ? imem_req : ack_force;
  assign imem_rdata = ovr_en ? 32'h8C22_0004 : ~imem_addr;
  fetch_stage dut (
    .CLK(CLK), .RST(RST), .Stall(Stall), .Branch(Branch), .Branch_target(Branch_target),
    .JtoPC(JtoPC), .Jump_target(Jump_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .IF_ID_Instr(IF_ID_Instr),
    .IF_ID_PC4(IF_ID_PC4), .IF_ID_Valid(IF_ID_Valid), .Read1(Read1), .Read2(Read2)
  );
  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .CLK(CLK), .RST(RST), .Stall(1'b0), .Branch(1'b0), .Branch_target(32'h0),
    .JtoPC(1'b0), .Jump_target(32'h0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_req), .imem_rdata(~w_addr), .IF_ID_Instr(w_instr),
    .IF_ID_PC4(w_pc4), .IF_ID_Valid(w_valid), .Read1(w_rd1), .Read2(w_rd2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_req", {31'b0, imem_req}, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", {31'b0, IF_ID_Valid}, 0);
    chk("rst_instr", IF_ID_Instr, 0);
    chk("rst_pc4", IF_ID_PC4, 0);
    chk("w_rst_addr", w_addr, 32'hFFFF_FFF8);
    RST = 0;
    tick();
    chk("t1_req", {31'b0, imem_req}, 1);
    chk("t1_addr0", imem_addr, 0);
    chk("t1_valid0", {31'b0, IF_ID_Valid}, 0);
    chk("t5_addr0", w_addr, 32'hFFFF_FFF8);
    tick();
    chk("t1_addr4", imem_addr, 32'h4);
    chk("t1_pc4_4", IF_ID_PC4, 32'h4);
    chk("t1_valid1", {31'b0, IF_ID_Valid}, 1);
    chk("t1_instr", IF_ID_Instr, 32'hFFFF_FFFF);
    chk("t5_addr1", w_addr, 32'hFFFF_FFFC);
    chk("t5_instr", w_instr, 32'h0000_0007);
    chk("t5_rd1", {27'b0, w_rd1}, 0);
    chk("t5_rd2", {27'b0, w_rd2}, 0);
    tick();
    chk("t1_addr8", imem_addr, 32'h8);
    chk("t1_pc4_8", IF_ID_PC4, 32'h8);
    chk("t5_addr_wrap", w_addr, 32'h0);
    chk("t5_pc4_wrap", w_pc4, 32'h0);
    chk("t5_valid", {31'b0, w_valid}, 1);
    tick();
    chk("t1_addrC", imem_addr, 32'hC);
    chk("t1_pc4_C", IF_ID_PC4, 32'hC);
    tick();
    chk("t1_addr10", imem_addr, 32'h10);
    chk("t1_pc4_10", IF_ID_PC4, 32'h10);
    chk("t1_instr10", IF_ID_Instr, 32'hFFFF_FFF3);
    ovr_en = 1;
    Stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ovr_en = 0;
      chk("t2_req_hold", {31'b0, imem_req}, 0);
      chk("t2_pc4_frozen", IF_ID_PC4, 32'h10);
      chk("t2_instr_frozen", IF_ID_Instr, 32'hFFFF_FFF3);
      chk("t2_valid_frozen", {31'b0, IF_ID_Valid}, 1);
    end
    Stall = 0;
    tick();
    chk("t2_instr", IF_ID_Instr, 32'h8C22_0004);
    chk("t2_pc4", IF_ID_PC4, 32'h14);
    chk("t2_valid", {31'b0, IF_ID_Valid}, 1);
    chk("t2_read1", {27'b0, Read1}, 1);
    chk("t2_read2", {27'b0, Read2}, 2);
    chk("t2_req", {31'b0, imem_req}, 1);
    chk("t2_addr", imem_addr, 32'h14);
    ack_mode = 0;
    tick();
    chk("t3_bubble", {31'b0, IF_ID_Valid}, 0);
    chk("t3_addr_wait", imem_addr, 32'h14);
    Branch = 1;
    Branch_target = 32'h100;
    tick();
    Branch = 0;
    chk("t3_flush", {31'b0, IF_ID_Valid}, 0);
    chk("t3_stale_addr", imem_addr, 32'h14);
    chk("t3_stale_req", {31'b0, imem_req}, 1);
    tick();
    ack_force = 1;
    tick();
    ack_force = 0;
    ack_mode = 1;
    chk("t3_addr100", imem_addr, 32'h100);
    chk("t3_discard", IF_ID_Instr, 32'h8C22_0004);
    chk("t3_valid0", {31'b0, IF_ID_Valid}, 0);
    tick();
    chk("t3_instr100", IF_ID_Instr, 32'hFFFF_FEFF);
    chk("t3_pc4_104", IF_ID_PC4, 32'h104);
    chk("t3_valid1", {31'b0, IF_ID_Valid}, 1);
    Stall = 1;
    Branch = 1;
    JtoPC = 1;
    Jump_target = 32'h200;
    tick();
    Stall = 0;
    Branch = 0;
    JtoPC = 0;
    chk("t4_flush_stall", {31'b0, IF_ID_Valid}, 0);
    chk("t4_addr200", imem_addr, 32'h200);
    chk("t4_pc4_held", IF_ID_PC4, 32'h104);
    tick();
    chk("t4_pc4_204", IF_ID_PC4, 32'h204);
    chk("t4_instr200", IF_ID_Instr, 32'hFFFF_FDFF);
    chk("t4_valid", {31'b0, IF_ID_Valid}, 1);
    ack_mode = 0;
    Branch = 1;
    Branch_target = 32'h300;
    tick();
    Branch = 0;
    chk("t6_drain_addr", imem_addr, 32'h204);
    tick();
    RST = 1;
    ack_force = 1;
    tick();
    chk("t6_rst_req", {31'b0, imem_req}, 0);
    chk("t6_rst_addr", imem_addr, 0);
    chk("t6_rst_valid", {31'b0, IF_ID_Valid}, 0);
    chk("t6_rst_instr", IF_ID_Instr, 0);
    chk("t6_rst_pc4", IF_ID_PC4, 0);
    RST = 0;
    tick();
    chk("t6_boot_ignore_valid", {31'b0, IF_ID_Valid}, 0);
    chk("t6_boot_ignore_instr", IF_ID_Instr, 0);
    chk("t6_restart_addr", imem_addr, 0);
    chk("t6_restart_req", {31'b0, imem_req}, 1);
    ack_force = 0;
    ack_mode = 1;
    tick();
    chk("t6_pc4", IF_ID_PC4, 32'h4);
    chk("t6_valid", {31'b0, IF_ID_Valid}, 1);
    chk("t6_addr4", imem_addr, 32'h4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
